ex_div: RTL and testbench
=========================

# ex_div

Iterative 32-cycle divider for the EX stage. Serves DIV/DIVU, the operations whose operands arrive on the ID/EX register outputs (`ex_opv1`, `ex_opv2`). It latches dividend and divisor, runs a radix-2 restoring division, and returns a 64-bit {remainder, quotient} for HI/LO. While a division is in flight it asserts a stall request so the ID/EX register holds its contents and the instruction stays in EX.

## Interface

- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`.

- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: a divide is requested. Level signal, held by EX while the instruction sits in EX.
- `signed_div` in 1: 1 selects DIV (signed), 0 selects DIVU. Sampled with `start` in IDLE.
- `opv1` in WIDTH: dividend. Sampled only in IDLE.
- `opv2` in WIDTH: divisor. Sampled only in IDLE.
- `annul` in 1: cancel the current division (flush or exception).
- `result` out 2*WIDTH: {remainder[2W-1:W], quotient[W-1:0]}. Valid while `ready`=1.
- `ready` out 1: one-cycle pulse marking the cycle `result` is valid.
- `stall_req` out 1: combinational stall request to pipeline control.

## Operation

- The FSM has four states: IDLE, BUSY, DONE, and ZERO_DONE. ZERO_DONE behaves as DONE with a zero result.
- IDLE, `start`=1, `annul`=0, `opv2`≠0:
  - Latch operands. If `signed_div`, use their absolute values.
  - Latch the sign of the quotient and the sign of the remainder.
  - Clear the iteration counter. Go to BUSY.
- IDLE, `start`=1, `annul`=0, `opv2`=0: go to ZERO_DONE.
- BUSY: perform one restoring step per cycle.
  - Shift the {partial remainder, dividend} pair left by 1.
  - Compute trial = partial remainder − divisor on WIDTH+1 bits.
  - If the trial is non-negative, keep the difference and set the quotient bit to 1.
  - Increment the counter. After step WIDTH−1, go to DONE.
- DONE:
  - Sign-correct the outputs. Negate the quotient if the operand signs differed. The remainder takes the sign of the dividend. Both are two's complement modulo 2^WIDTH.
  - Drive `result` and set `ready`=1. Go to IDLE unconditionally on the next edge.
- ZERO_DONE: `result`=0, `ready`=1, then go to IDLE.
- Signed 0x80000000 / 0xFFFFFFFF needs no trap: the modulo arithmetic gives quotient 0x80000000 and remainder 0.
- `stall_req` = `rst` & `start` & ~`ready` & ~`annul`.
- `annul`=1 in any state: go to IDLE on the next edge, clear the counter, and hold `ready` at 0. Annul takes precedence over `start` in the same cycle.
- Operand changes while in BUSY are ignored.
- Outside DONE and ZERO_DONE, `result` is forced to 0.

## Timing

- Reset (`rst`=0, asynchronous) puts the block in this state immediately:
  - state IDLE, counter 0, internal operand and remainder registers 0.
  - `result`=0, `ready`=0, `stall_req`=0.
- Nonzero divisor, `start` first seen in IDLE at cycle T:
  - BUSY for T+1 through T+WIDTH.
  - DONE at T+WIDTH+1, with `ready`=1 and `stall_req`=0.
  - Back in IDLE at T+WIDTH+2.
  - `stall_req` is high for cycles T through T+WIDTH.
- Zero divisor: ZERO_DONE at T+1, `stall_req` high only in cycle T.
- Back-to-back divides: the pipeline advances on the DONE edge. A new `start` in the following IDLE cycle begins a fresh division with no bubble beyond that IDLE cycle.
- `start` still high in the DONE cycle does not re-trigger, because DONE always exits to IDLE.
- Release of `rst` mid-division: a new divide starts only when `start` is seen in IDLE.

## Structure

- Shared defines package holds:
  - the aluop codes `EXE_DIV_OP` and `EXE_DIVU_OP` (EX derives `start`/`signed_div` from these),
  - the FSM state encodings,
  - `DIV_CYCLES`.
- Single module, no sub-module. The restoring step is one combinational subtract inside the module.

## Test plan

- DIVU 100 / 7, start at T: `ready` at T+33, `result`=0x00000002_0000000E, `stall_req` high T..T+32.
- DIV −7 (0xFFFFFFF9) / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2: quotient 0xFFFFFFFD, remainder 0x00000001.
- Edge operands:
  - DIVU 5 / 0: `ready` at T+1, `result`=0, `stall_req` high only at T.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - DIVU 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- Annul during BUSY:
  - `annul` at BUSY step 10 returns the FSM to IDLE next cycle; `ready` never pulses; `stall_req` is 0 while `annul` is high.
  - A new DIVU 9 / 3 three cycles later yields 0x00000000_00000003 at 33 cycles.
- Back-to-back DIVU 20/3 then 21/4 with `start` held: results 0x00000002_00000006 then 0x00000001_00000005. The second starts one cycle after the first DONE.
- Reset during BUSY: `rst`=0 asynchronously clears `result`, `ready`, and `stall_req` within the same cycle. After release, DIVU 8 / 2 completes with 0x00000000_00000004.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage iterative divider.
package ex_div_pkg;

  localparam int unsigned DIV_CYCLES = 32;

  // ALU operation codes that EX decodes into start/signed_div.
  localparam int unsigned ALUOP_W = 8;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE      = 2'b00,
    DIV_BUSY      = 2'b01,
    DIV_DONE      = 2'b10,
    DIV_ZERO_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} and holds EX via stall_req while busy.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opv1,
  input  logic [WIDTH-1:0]   opv2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             quo_neg_q;
  logic             rem_neg_q;

  logic             op1_neg_c, op2_neg_c, divisor_zero_c;
  logic [WIDTH-1:0] abs1_c, abs2_c;
  logic [WIDTH:0]   shifted_rem_c, trial_c;
  logic [WIDTH-1:0] rem_nxt_c, quo_nxt_c;
  logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

  // Operand magnitudes for the signed case.
  always_comb begin
    op1_neg_c      = signed_div & opv1[WIDTH-1];
    op2_neg_c      = signed_div & opv2[WIDTH-1];
    abs1_c         = op1_neg_c ? (~opv1 + WIDTH'(1)) : opv1;
    abs2_c         = op2_neg_c ? (~opv2 + WIDTH'(1)) : opv2;
    divisor_zero_c = (opv2 == '0);
  end

  // One restoring step: shift, trial subtract on WIDTH+1 bits, keep if non-negative.
  always_comb begin
    shifted_rem_c = {rem_q, dvd_q[WIDTH-1]};
    trial_c       = shifted_rem_c - {1'b0, dvs_q};
    rem_nxt_c     = trial_c[WIDTH] ? shifted_rem_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
    quo_nxt_c     = {dvd_q[WIDTH-2:0], ~trial_c[WIDTH]};
    quo_fix_c     = quo_neg_q ? (WIDTH'(0) - quo_nxt_c) : quo_nxt_c;
    rem_fix_c     = rem_neg_q ? (WIDTH'(0) - rem_nxt_c) : rem_nxt_c;
  end

  // Next-state selection; annul overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) state_d = divisor_zero_c ? DIV_ZERO_DONE : DIV_BUSY;
      end
      DIV_BUSY: begin
        if (cnt_q == LAST_STEP) state_d = DIV_DONE;
      end
      DIV_DONE:      state_d = DIV_IDLE;
      DIV_ZERO_DONE: state_d = DIV_IDLE;
      default:       state_d = DIV_IDLE;
    endcase
    if (annul) state_d = DIV_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DIV_IDLE;
    else      state_q <= state_d;
  end

  // Datapath and registered outputs; result/ready are only live in DONE/ZERO_DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else begin
      result <= '0;
      ready  <= 1'b0;
      if (annul) begin
        cnt_q <= '0;
      end else begin
        case (state_q)
          DIV_IDLE: begin
            if (start && !divisor_zero_c) begin
              dvd_q     <= abs1_c;
              dvs_q     <= abs2_c;
              rem_q     <= '0;
              quo_neg_q <= op1_neg_c ^ op2_neg_c;
              rem_neg_q <= op1_neg_c;
              cnt_q     <= '0;
            end else if (start) begin
              ready <= 1'b1;
            end
          end
          DIV_BUSY: begin
            rem_q <= rem_nxt_c;
            dvd_q <= quo_nxt_c;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              ready  <= 1'b1;
              result <= {rem_fix_c, quo_fix_c};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Hold ID/EX while a requested divide has not yet produced its result.
  assign stall_req = rst & start & ~ready & ~annul;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: driver pushes expected {result, cycle}, monitor checks on ready.
module tb_ex_div;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_div;
  logic [W-1:0]   opv1;
  logic [W-1:0]   opv2;
  logic           annul;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stall_req;

  typedef struct {
    logic [2*W-1:0] res;
    int             cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   done_ok;

  ex_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opv1       (opv1),
    .opv2       (opv2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ready pulse must match the oldest expectation in value and cycle.
  always @(posedge clk) begin
    #1;
    if (ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: result=%h at cycle %0d, required no pulse", result, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        n_vec++;
        if (result !== mon_e.res) begin
          n_err++;
          $display("FAIL result: got %h, required %h (cycle %0d)", result, mon_e.res, cyc);
        end
        n_vec++;
        if (cyc != mon_e.cyc) begin
          n_err++;
          $display("FAIL ready_cycle: got %0d, required %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Present a divide in the current (IDLE) cycle T; optionally expect a result at T+lat.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input int lat, input bit track);
    start      = 1'b1;
    signed_div = s;
    opv1       = a;
    opv2       = b;
    if (track) sb_q.push_back('{exp, cyc + lat});
    #1;
    check("stall_at_start", 64'(stall_req), 64'd1);
  endtask

  // Wait for ready with a bound; stall must stay high and result zero until then.
  task automatic wait_done(output bit ok);
    int bad_stall = 0;
    int bad_res   = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (stall_req !== 1'b1) bad_stall++;
      if (result !== '0) bad_res++;
    end
    check("stall_while_busy", 64'(bad_stall), 64'd0);
    check("result_zero_while_busy", 64'(bad_res), 64'd0);
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got no ready in 100 cycles, required a pulse");
    end else begin
      check("stall_in_done", 64'(stall_req), 64'd0);
    end
  endtask

  task automatic single(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int lat);
    @(posedge clk);
    #1;
    issue(s, a, b, exp, lat, 1'b1);
    wait_done(done_ok);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    start      = 1'b1;
    signed_div = 1'b0;
    opv1       = 32'd100;
    opv2       = 32'd7;
    annul      = 1'b0;
    #12;
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;

    // Directed vectors: signed flag, dividend, divisor, {rem, quo}, latency.
    single(1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);
    single(1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33);
    single(1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33);
    single(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33);
    single(1'b0, 32'd5,          32'd0,          64'h00000000_00000000, 1);
    single(1'b1, 32'hFFFFFFFB,   32'd0,          64'h00000000_00000000, 1);
    single(1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33);
    single(1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33);
    single(1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33);
    single(1'b0, 32'hFFFFFFFF,   32'h00010000,   64'h0000FFFF_0000FFFF, 33);

    // Annul at BUSY step 10, then a fresh DIVU 9/3.
    @(posedge clk);
    #1;
    issue(1'b0, 32'd1000, 32'd7, '0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    #1;
    check("stall_during_annul", 64'(stall_req), 64'd0);
    @(posedge clk);
    #1;
    annul = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    issue(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b1);
    wait_done(done_ok);
    @(posedge clk);
    #1;
    start = 1'b0;

    // Back-to-back with start held across the DONE edge.
    @(posedge clk);
    #1;
    issue(1'b0, 32'd20, 32'd3, 64'h00000002_00000006, 33, 1'b1);
    wait_done(done_ok);
    @(posedge clk);
    #1;
    issue(1'b0, 32'd21, 32'd4, 64'h00000001_00000005, 33, 1'b1);
    wait_done(done_ok);
    @(posedge clk);
    #1;
    start = 1'b0;

    // Asynchronous reset in the middle of BUSY.
    @(posedge clk);
    #1;
    issue(1'b0, 32'd50, 32'd5, '0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("busy_reset_result", result, 64'd0);
    check("busy_reset_ready", 64'(ready), 64'd0);
    check("busy_reset_stall", 64'(stall_req), 64'd0);
    start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    issue(1'b0, 32'd8, 32'd2, 64'h00000000_00000004, 33, 1'b1);
    wait_done(done_ok);

    // Asynchronous reset while the result is being presented.
    #1 rst = 1'b0;
    #1;
    check("done_reset_result", result, 64'd0);
    check("done_reset_ready", 64'(ready), 64'd0);
    check("done_reset_stall", 64'(stall_req), 64'd0);
    start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;

    repeat (5) @(posedge clk);
    #2;
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
